gate_sweep: RTL
===============

Name: gate_sweep

Overview:
- Parametrised successor to the fixed 2-input NOR lab cell: N-input logic unit with 8 selectable gate functions and a registered output.
- Built-in exhaustive sweeper: on request, steps through all 2^N input vectors and captures the complete truth table into a register, so benches and lab boards can check the whole table in one run.
- Sits beside the Week-1 gate cells as a self-checking gate-characterisation block.

Parameters:
- N, 2, number of gate inputs; legal range 1..6.
- TT, 2**N, truth-table width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active high
- a  in  N  direct operand vector, used when not sweeping
- mode  in  3  function select: 0 NOR, 1 NAND, 2 AND, 3 OR, 4 XOR (odd parity), 5 XNOR, 6 INV of bit 0, 7 BUF of bit 0
- start  in  1  sweep request, sampled in IDLE only
- y  out  1  registered gate result
- vec  out  N  current sweep vector (counter value)
- busy  out  1  high while in SWEEP
- done  out  1  one-cycle pulse after the sweep completes
- table  out  TT  captured truth table; bit i = f(mode, vector i)

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-sweep: state=IDLE; y=0; vec=0; busy=0; done=0; table=0; mode_q=0. Partial sweep results are discarded.
- f(m, v) is the combinational function selected by m, applied to the N-bit vector v.
- Operand select: op = busy ? vec : a.
- Function select: fsel = busy ? mode_q : mode.
- y <= f(fsel, op) every edge. Latency from a or mode to y is one cycle.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - start=1 at edge k: state<=SWEEP, vec<=0, mode_q<=mode, table<=0.
  - Otherwise hold.
- SWEEP, each edge:
  - table[vec] <= f(mode_q, vec).
  - If vec == TT-1: state<=DONE, vec holds at TT-1.
  - Else: vec<=vec+1.
  - Exactly TT writes occur, at edges k+1 .. k+TT.
- DONE: lasts one cycle (done=1), then state<=IDLE. vec resets to 0 on that exit edge.
- Outputs: busy=(state==SWEEP); done=(state==DONE). Both registered and decoded from state, glitch-free.
- Latency: start edge k to done high = TT+1 edges. table is final when done is high and holds until the next start or rst.
- start while in SWEEP or DONE is ignored; it is not queued.
- mode or a changes during SWEEP do not affect the sweep; y during SWEEP tracks f(mode_q, vec).
- start held high continuously: a new sweep begins on the first edge back in IDLE, giving a TT+2-cycle period.
- vec never exceeds TT-1; there is no wrap-around inside a sweep.
- N=1: TT=2, two writes. Functions 6 and 7 use bit 0 for all N.

Test Plan:
- Reset, then check all four a combinations with mode=0, N=2:
  - a=00→y=1; 01,10,11→y=0, each one cycle late.
  - Equals the original NOR truth table.
- N=2 sweep for each mode 0..7; required table at done:
  - 0001 (NOR), 0111 (NAND), 1000 (AND), 1110 (OR)
  - 0110 (XOR), 1001 (XNOR), 0101 (INV), 1010 (BUF)
  - done is high exactly 5 cycles after the start edge; busy is high for 4 cycles.
- During an N=2 NAND sweep:
  - Toggle mode to 3 and pulse start at cycle 2 → table still 0111, no second sweep, done pulses once.
- rst asserted in the 3rd SWEEP cycle:
  - Next cycle: busy=0, table=0, vec=0, y=0.
  - A new start then completes normally.
- N=3, mode 4 (XOR) → table=8'b10010110 after 9 cycles.
- N=3, mode 0 (NOR) → table=8'b00000001.
- start held high for 20 cycles, N=2:
  - done pulses at cycles 5, 11 and 17 (period 6).
  - vec is 0 in every IDLE cycle.

Source files
------------

// File: rtl/gate_sweep.sv
// N-input logic unit with eight selectable gate functions, a registered output,
// and a sweeper that records the whole truth table of the selected function.
module gate_sweep #(
  parameter int N = 2,
  localparam int TT = 1 << N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  a,
  input  logic [2:0]    mode,
  input  logic          start,
  output logic          y,
  output logic [N-1:0]  vec,
  output logic          busy,
  output logic          done,
  output logic [TT-1:0] truth_table
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [N-1:0] VEC_LAST = {N{1'b1}};

  state_t         state_r;
  logic [2:0]     mode_q_r;
  logic [N-1:0]   op_s;
  logic [2:0]     fsel_s;

  // Selected gate function applied to an N-bit vector; INV/BUF look at bit 0 only.
  function automatic logic gate_fn(input logic [2:0] m, input logic [N-1:0] v);
    logic r;
    case (m)
      3'd0:    r = ~(|v);
      3'd1:    r = ~(&v);
      3'd2:    r = &v;
      3'd3:    r = |v;
      3'd4:    r = ^v;
      3'd5:    r = ~(^v);
      3'd6:    r = ~v[0];
      3'd7:    r = v[0];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // While sweeping, the counter and the captured mode replace the live inputs.
  always_comb begin
    op_s   = a;
    fsel_s = mode;
    if (busy) begin
      op_s   = vec;
      fsel_s = mode_q_r;
    end else begin
      op_s   = a;
      fsel_s = mode;
    end
  end

  // Sweep FSM; busy/done are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      y           <= 1'b0;
      vec         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
      mode_q_r    <= 3'd0;
    end else begin
      y <= gate_fn(fsel_s, op_s);
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r     <= SWEEP;
            busy        <= 1'b1;
            done        <= 1'b0;
            vec         <= '0;
            mode_q_r    <= mode;
            truth_table <= '0;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        SWEEP: begin
          truth_table[vec] <= gate_fn(mode_q_r, vec);
          if (vec == VEC_LAST) begin
            // Counter parks on the last vector; it is cleared on the way back to IDLE.
            state_r <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            vec <= vec + {{(N-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          vec     <= '0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          vec     <= '0;
        end
      endcase
    end
  end

endmodule
